// File: rtl/bus_slave_mux_tmo.sv
// bus_slave_mux_tmo: registered slave-response mux with access tracking,
// per-access timeout and a saturating bus-error counter.
//
// state | meaning
// IDLE  | waiting for an address strobe
// WAIT  | access in flight, counting cycles until the slave is ready
// DONE  | one-cycle normal response on the output registers
// ERR   | one-cycle error response (decode error or timeout)
module bus_slave_mux_tmo #(
  parameter int SLAVE_NUM  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TMO_CYCLES = 255,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset_,
  input  logic                            as_,
  input  logic [SLAVE_NUM-1:0]            cs_,
  input  logic [SLAVE_NUM-1:0]            s_ready_,
  input  logic [SLAVE_NUM*DATA_WIDTH-1:0] s_rd_data,
  output logic                            out_ready_,
  output logic [DATA_WIDTH-1:0]           out_rd_data,
  output logic                            out_err,
  output logic [7:0]                      err_cnt
);

  localparam int SEL_W = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TMO_CYCLES - 1);

  logic [1:0]            state, state_nxt;
  logic [SEL_W-1:0]      sel, sel_nxt;
  logic [TMO_WIDTH-1:0]  timer, timer_nxt;
  logic                  dec_hit;
  logic [SEL_W-1:0]      dec_idx;
  logic [SEL_W-1:0]      mux_idx;
  logic                  mux_rdy_;
  logic                  mux_cs_;
  logic [DATA_WIDTH-1:0] mux_data;
  logic                  resp_done;
  logic                  resp_err;

  // Priority decode: scanning downward leaves the lowest active chip select.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (!cs_[i]) begin
        dec_hit = 1'b1;
        dec_idx = SEL_W'(i);
      end
    end
  end

  // In IDLE the fresh decode steers the mux so a same-cycle ready is caught;
  // afterwards the latched selection is used and cs_ is not re-decoded.
  assign mux_idx = (state == ST_IDLE) ? dec_idx : sel;

  // Slave mux for ready, chip select and read data of the steered slave.
  always_comb begin
    mux_rdy_ = 1'b1;
    mux_cs_  = 1'b1;
    mux_data = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (SEL_W'(i) == mux_idx) begin
        mux_rdy_ = s_ready_[i];
        mux_cs_  = cs_[i];
        mux_data = s_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next-state logic; ready takes priority over withdraw and timeout.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    timer_nxt = timer;
    case (state)
      ST_IDLE: begin
        if (!as_) begin
          if (!dec_hit) begin
            state_nxt = ST_ERR;
          end else begin
            sel_nxt = dec_idx;
            if (!mux_rdy_) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_WAIT;
              timer_nxt = '0;
            end
          end
        end
      end
      ST_WAIT: begin
        if (!mux_rdy_) begin
          state_nxt = ST_DONE;
        end else if (mux_cs_) begin
          state_nxt = ST_IDLE;
        end else if (timer == TMO_LAST) begin
          state_nxt = ST_ERR;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // DONE/ERR always return to IDLE, so entering them marks a fresh response.
  assign resp_done = (state_nxt == ST_DONE);
  assign resp_err  = (state_nxt == ST_ERR);

  // State, latched selection and wait timer.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state <= ST_IDLE;
      sel   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      timer <= timer_nxt;
    end
  end

  // Response registers: loaded on the edge that enters DONE/ERR, so they are
  // valid for exactly the one cycle spent in that state.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      out_ready_  <= 1'b1;
      out_rd_data <= '0;
      out_err     <= 1'b0;
    end else begin
      out_ready_  <= ~(resp_done | resp_err);
      out_rd_data <= resp_done ? mux_data : '0;
      out_err     <= resp_err;
    end
  end

  // Saturating error counter.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_cnt <= 8'h00;
    end else if (resp_err && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_bus_slave_mux_tmo.sv
// Testbench for bus_slave_mux_tmo: directed and randomized accesses checked
// against a transaction-level model of response cycle, data and error count.
module tb_bus_slave_mux_tmo;

  localparam int SN  = 8;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic             clk = 1'b0;
  logic             reset_;
  logic             as_;
  logic [SN-1:0]    cs_;
  logic [SN-1:0]    s_ready_;
  logic [SN*DW-1:0] s_rd_data;
  logic             out_ready_;
  logic [DW-1:0]    out_rd_data;
  logic             out_err;
  logic [7:0]       err_cnt;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int model_cnt = 0;

  bit          fix_en = 1'b0;
  logic [31:0] fix_data [SN];

  bus_slave_mux_tmo #(
    .SLAVE_NUM (SN),
    .DATA_WIDTH(DW),
    .TMO_CYCLES(TMO),
    .TMO_WIDTH (8)
  ) dut (
    .clk        (clk),
    .reset_     (reset_),
    .as_        (as_),
    .cs_        (cs_),
    .s_ready_   (s_ready_),
    .s_rd_data  (s_rd_data),
    .out_ready_ (out_ready_),
    .out_rd_data(out_rd_data),
    .out_err    (out_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_rdy, input logic [31:0] exp_data,
                           input logic exp_err);
    chk({tag, ".ready_"}, {31'b0, out_ready_}, {31'b0, exp_rdy});
    chk({tag, ".data"}, out_rd_data, exp_data);
    chk({tag, ".err"}, {31'b0, out_err}, {31'b0, exp_err});
    chk({tag, ".err_cnt"}, {24'b0, err_cnt}, model_cnt[31:0]);
  endtask

  task automatic drive_data();
    for (int i = 0; i < SN; i++)
      s_rd_data[i*DW +: DW] = fix_en ? fix_data[i] : $urandom();
  endtask

  function automatic int lowest_sel(input logic [SN-1:0] cs_v);
    for (int i = 0; i < SN; i++)
      if (!cs_v[i]) return i;
    return -1;
  endfunction

  // One access: strobe in cycle 0, selected slave ready in cycle rdy_c (-1 never),
  // master withdraws cs_[sel] from cycle wd_c on (-1 never). extra_rdy marks
  // other slaves that also go ready in the ready cycle.
  task automatic run_txn(input string tag, input logic [SN-1:0] cs_v, input int rdy_c,
                         input int wd_c, input logic [SN-1:0] extra_rdy);
    int          sel;
    int          resp;
    int          last;
    logic        exp_e;
    logic [31:0] exp_d;
    sel   = lowest_sel(cs_v);
    exp_e = 1'b0;
    exp_d = '0;
    if (sel < 0) begin
      resp  = 1;
      exp_e = 1'b1;
    end else if (rdy_c >= 0 && rdy_c <= TMO && (wd_c < 1 || rdy_c <= wd_c)) begin
      resp = rdy_c + 1;
    end else if (wd_c >= 1 && wd_c <= TMO) begin
      resp = -1;
    end else begin
      resp  = TMO + 1;
      exp_e = 1'b1;
    end
    last = (resp > 0) ? resp + 1 : wd_c + 2;

    for (int c = 0; c <= last; c++) begin
      @(posedge clk);
      #1;
      as_ = (c == 0) ? 1'b0 : 1'b1;
      cs_ = cs_v;
      s_ready_ = SN'($urandom());
      if (sel >= 0) begin
        if (wd_c >= 1 && c >= wd_c) cs_[sel] = 1'b1;
        s_ready_[sel] = (c == rdy_c) ? 1'b0 : 1'b1;
        if (c == rdy_c) s_ready_ = s_ready_ & ~extra_rdy;
      end
      drive_data();
      if (sel >= 0 && c == rdy_c) exp_d = s_rd_data[sel*DW +: DW];
      @(negedge clk);
      if (c == resp) begin
        if (exp_e && model_cnt < 255) model_cnt++;
        check_out(tag, 1'b0, exp_e ? 32'h0 : exp_d, exp_e);
      end else begin
        check_out(tag, 1'b1, 32'h0, 1'b0);
      end
    end
  endtask

  initial begin
    logic [SN-1:0] rcs;
    int            rr;
    int            rw;

    // Reset held with random inputs.
    reset_    = 1'b0;
    as_       = 1'b1;
    cs_       = '1;
    s_ready_  = '1;
    s_rd_data = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      as_      = 1'($urandom());
      cs_      = SN'($urandom());
      s_ready_ = SN'($urandom());
      drive_data();
      @(negedge clk);
      check_out("reset_hold", 1'b1, 32'h0, 1'b0);
    end
    @(posedge clk);
    #1;
    reset_   = 1'b1;
    as_      = 1'b1;
    cs_      = '1;
    s_ready_ = '1;

    // Normal read from slave 2, ready three cycles after the strobe.
    fix_en = 1'b1;
    for (int i = 0; i < SN; i++) fix_data[i] = 32'h1000_0000 + i;
    fix_data[2] = 32'hDEADBEEF;
    run_txn("normal_read", 8'hFB, 3, -1, 8'h00);

    // Two selects: lowest index wins even when both are ready.
    fix_data[2] = 32'h22;
    fix_data[3] = 32'h33;
    run_txn("multi_sel", 8'hF3, 1, -1, 8'h08);
    run_txn("multi_sel_same", 8'hF3, 0, -1, 8'h08);
    fix_en = 1'b0;

    // Timeout on slave 5 and the ready/timeout boundary.
    run_txn("timeout", 8'hDF, -1, -1, 8'h00);
    run_txn("ready_last_wait", 8'hDF, TMO, -1, 8'h00);
    run_txn("ready_too_late", 8'hDF, TMO + 1, -1, 8'h00);

    // Withdraw: silent abort, also at the last wait cycle; ready wins over withdraw.
    run_txn("abort", 8'hFB, -1, 3, 8'h00);
    run_txn("abort_last", 8'hFB, -1, TMO, 8'h00);
    run_txn("ready_vs_withdraw", 8'hFB, 4, 4, 8'h00);

    // Randomized accesses.
    for (int n = 0; n < 150; n++) begin
      rcs = SN'($urandom() | $urandom());
      rr  = int'($urandom_range(0, TMO + 3)) - 1;
      rw  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, TMO + 2));
      run_txn("random", rcs, rr, rw, SN'($urandom()));
    end

    // Decode errors until the counter saturates.
    for (int n = 0; n < 300; n++) run_txn("decode_err", 8'hFF, -1, -1, 8'h00);
    chk("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);

    // Asynchronous reset in the middle of a wait: no late response afterwards.
    @(posedge clk);
    #1;
    as_      = 1'b0;
    cs_      = 8'hDF;
    s_ready_ = '1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      as_ = 1'b1;
    end
    #2;
    reset_    = 1'b0;
    model_cnt = 0;
    #1;
    check_out("reset_mid_wait", 1'b1, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    reset_   = 1'b1;
    s_ready_ = '0;
    drive_data();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_out("after_reset", 1'b1, 32'h0, 1'b0);
    end
    s_ready_ = '1;

    // Normal operation resumes after reset.
    run_txn("post_reset_read", 8'h7F, 2, -1, 8'h00);
    run_txn("post_reset_err", 8'hFF, -1, -1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
